call_ctrl: RTL and testbench
============================

# call_ctrl

Control-flow sequencer for subroutine calls, returns and interrupt entry. It sits directly upstream of `call_stack`: it drives that block's push, pop and data inputs, and consumes its data output. It also tracks stack depth, which `call_stack` does not do; `call_stack` silently wraps. It delivers PC redirects to the fetch stage and gates interrupts.

## Interface
Parameters:
- `STACK_DEPTH`, 16: usable entries in `call_stack`; the ovf limit.
- `IRQ_VECTOR`, 16'h0010: PC target on interrupt entry.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low. The same net, inverted, drives `call_stack` reset.
- `stall`  in  1  pipeline hold (data_hazard); blocks request acceptance and holds `pc_load`.
- `call_req`  in  1  CALL request.
- `call_addr`  in  16  CALL target.
- `ret_pc`  in  16  return address for CALL (instruction after CALL).
- `ret_req`  in  1  RET request.
- `reti_req`  in  1  RETI request (RET that also clears `in_isr`).
- `irq_req`  in  1  level interrupt request, held until `irq_ack`.
- `irq_en`  in  1  global interrupt enable.
- `cur_pc`  in  16  resume address pushed on interrupt entry.
- `cs_data_out`  in  16  `call_stack` top-of-stack read data.
- `cs_push`  out  1  `call_stack` push strobe.
- `cs_pop`  out  1  `call_stack` pop strobe.
- `cs_data_in`  out  16  `call_stack` write data.
- `pc_load`  out  1  PC redirect valid.
- `pc_target`  out  16  PC redirect address.
- `busy`  out  1  state ≠ IDLE.
- `req_taken`  out  1  one-cycle pulse: a request was accepted (including faulted requests).
- `irq_ack`  out  1  one-cycle pulse on interrupt acceptance.
- `in_isr`  out  1  interrupt service in progress.
- `depth`  out  5  current stack occupancy, 0..STACK_DEPTH.
- `fault_ovf`  out  1  sticky: push attempted at full.
- `fault_unf`  out  1  sticky: pop attempted at empty.

## Operation
- **States:** IDLE, PUSH, POP, WAIT, LOAD. All outputs are registered.
- **Acceptance:** only in IDLE at an edge with `stall`=0. Otherwise requests are ignored; upstream holds them until `req_taken`.
- **Priority:** irq (`irq_req & irq_en & ~in_isr`) > `reti_req` > `ret_req` > `call_req`. Losers are not taken.
- **CALL:**
  - Accept edge: `depth`+1, `cs_data_in`←`ret_pc`, `pc_target`←`call_addr`.
  - Sequence: PUSH (`cs_push`=1, one cycle) → LOAD.
- **IRQ:**
  - As CALL, with `cs_data_in`←`cur_pc` and `pc_target`←IRQ_VECTOR.
  - `irq_ack` pulses and `in_isr`←1 on the accept edge.
- **RET/RETI:**
  - Accept edge: `depth`−1.
  - Sequence: POP (`cs_pop`=1, one cycle) → WAIT. At the WAIT→LOAD edge, `pc_target`←`cs_data_out`.
  - RETI clears `in_isr` at that same edge.
- **LOAD:** `pc_load`=1 held. Exit to IDLE at the first edge with `stall`=0.
- **Overflow:** push request (CALL/IRQ) with `depth`==STACK_DEPTH.
  - `fault_ovf`←1 and `req_taken` pulses.
  - No push, no redirect, no `irq_ack`, `in_isr` unchanged; stays IDLE.
- **Underflow:** RET/RETI with `depth`==0.
  - `fault_unf`←1 and `req_taken` pulses.
  - No pop, no redirect, `in_isr` unchanged; stays IDLE.
- Faults clear only on reset. Further requests are still serviced after a fault.
- **Depth arithmetic:** 5-bit unsigned. Never exceeds STACK_DEPTH and never wraps below 0.

## Timing
- **Reset** (`rst`=0 at an edge):
  - State IDLE; `depth`=0.
  - All strobes, `busy`, `in_isr` and faults are 0.
  - `pc_target`=0 and `cs_data_in`=0.
- **Reset mid-operation:** takes effect at the next edge. Any pending push, pop or load is abandoned, with no `pc_load` afterwards.
- **Edge E0 = accept.**
- **CALL/IRQ:**
  - `req_taken`, `cs_push` and `busy` high in cycle 1.
  - `pc_load` high from cycle 2; back in IDLE in cycle 3 if `stall`=0 at E2.
  - Next request acceptable at E3.
- **RET/RETI:**
  - `cs_pop` in cycle 1; WAIT in cycle 2 (`cs_data_out` valid, captured at E2).
  - `pc_load` from cycle 3; IDLE in cycle 4 if no stall.
- **`stall` during PUSH/POP/WAIT:** no effect, since the stack handshake is not stallable. Stall only extends LOAD.
- **`irq_req` while `busy`:** waits; it is evaluated at the first eligible IDLE edge.
- **`pc_target`:** stable from entry to LOAD until the next accept.

## Test plan
- Reset, then CALL `call_addr`=16'h1234, `ret_pc`=16'h0101 → `cs_push` cycle 1 with `cs_data_in`=16'h0101; `pc_load` cycle 2 with `pc_target`=16'h1234; `depth`=1.
- RET following that CALL, `call_stack` returns 16'h0101 → `cs_pop` cycle 1; `pc_load` cycle 3 with `pc_target`=16'h0101; `depth`=0.
- 16 CALLs then a 17th → `depth`=16, `fault_ovf`=1, no 17th `cs_push`; then 16 RETs return `ret_pc` values in LIFO order; a 17th RET → `fault_unf`=1, no `cs_pop`.
- `irq_req`=1, `call_req`=1 same cycle, `irq_en`=1, `cur_pc`=16'h0200 → `irq_ack`, push 16'h0200, `pc_target`=16'h0010, `in_isr`=1; CALL taken afterwards; second `irq_req` ignored until RETI clears `in_isr`.
- `stall`=1 for 3 cycles starting at LOAD of a CALL → `pc_load` held 4 cycles, `pc_target` constant, IDLE the cycle after `stall` drops.
- `rst`=0 during RET WAIT → next cycle: IDLE, `depth`=0, `pc_load`=0 and never asserted for that RET.

Source files
------------

// File: rtl/call_ctrl_if.sv
// Request, redirect and call_stack handshake bundle for call_ctrl.
// The master side is the upstream pipeline plus call_stack; the slave side is call_ctrl.
interface call_ctrl_if;
    logic        stall;
    logic        call_req;
    logic [15:0] call_addr;
    logic [15:0] ret_pc;
    logic        ret_req;
    logic        reti_req;
    logic        irq_req;
    logic        irq_en;
    logic [15:0] cur_pc;
    logic [15:0] cs_data_out;

    logic        cs_push;
    logic        cs_pop;
    logic [15:0] cs_data_in;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        busy;
    logic        req_taken;
    logic        irq_ack;
    logic        in_isr;
    logic [4:0]  depth;
    logic        fault_ovf;
    logic        fault_unf;

    modport master (
        output stall, call_req, call_addr, ret_pc, ret_req, reti_req,
               irq_req, irq_en, cur_pc, cs_data_out,
        input  cs_push, cs_pop, cs_data_in, pc_load, pc_target, busy,
               req_taken, irq_ack, in_isr, depth, fault_ovf, fault_unf
    );

    modport slave (
        input  stall, call_req, call_addr, ret_pc, ret_req, reti_req,
               irq_req, irq_en, cur_pc, cs_data_out,
        output cs_push, cs_pop, cs_data_in, pc_load, pc_target, busy,
               req_taken, irq_ack, in_isr, depth, fault_ovf, fault_unf
    );
endinterface

// File: rtl/call_ctrl.sv
// CALL/RET/RETI/interrupt-entry sequencer in front of call_stack: tracks depth,
// drives push/pop, and issues PC redirects to fetch.
module call_ctrl #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter logic [15:0] IRQ_VECTOR  = 16'h0010
) (
    input logic        clk,
    input logic        rst,
    call_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PUSH = 3'd1;
    localparam logic [2:0] S_POP  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_LOAD = 3'd4;

    localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

    logic [2:0] state;
    logic       reti_q;
    logic       accept;
    logic       irq_go;
    logic       push_go;
    logic       pop_go;

    // Priority: enabled irq outside an ISR, then RETI, then RET, then CALL.
    always_comb begin
        accept  = (state == S_IDLE) && !bus.stall;
        irq_go  = bus.irq_req && bus.irq_en && !bus.in_isr;
        pop_go  = !irq_go && (bus.reti_req || bus.ret_req);
        push_go = irq_go || (!bus.reti_req && !bus.ret_req && bus.call_req);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            reti_q         <= 1'b0;
            bus.cs_push    <= 1'b0;
            bus.cs_pop     <= 1'b0;
            bus.cs_data_in <= '0;
            bus.pc_load    <= 1'b0;
            bus.pc_target  <= '0;
            bus.busy       <= 1'b0;
            bus.req_taken  <= 1'b0;
            bus.irq_ack    <= 1'b0;
            bus.in_isr     <= 1'b0;
            bus.depth      <= '0;
            bus.fault_ovf  <= 1'b0;
            bus.fault_unf  <= 1'b0;
        end else begin
            bus.cs_push   <= 1'b0;
            bus.cs_pop    <= 1'b0;
            bus.req_taken <= 1'b0;
            bus.irq_ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && push_go) begin
                        bus.req_taken <= 1'b1;
                        // A push at full is swallowed: flagged and acknowledged, nothing else moves.
                        if (bus.depth == DEPTH_MAX) begin
                            bus.fault_ovf <= 1'b1;
                        end else begin
                            state          <= S_PUSH;
                            bus.busy       <= 1'b1;
                            bus.cs_push    <= 1'b1;
                            bus.depth      <= bus.depth + 5'd1;
                            bus.cs_data_in <= irq_go ? bus.cur_pc : bus.ret_pc;
                            bus.pc_target  <= irq_go ? IRQ_VECTOR : bus.call_addr;
                            if (irq_go) begin
                                bus.irq_ack <= 1'b1;
                                bus.in_isr  <= 1'b1;
                            end
                        end
                    end else if (accept && pop_go) begin
                        bus.req_taken <= 1'b1;
                        if (bus.depth == 5'd0) begin
                            bus.fault_unf <= 1'b1;
                        end else begin
                            state      <= S_POP;
                            bus.busy   <= 1'b1;
                            bus.cs_pop <= 1'b1;
                            bus.depth  <= bus.depth - 5'd1;
                            reti_q     <= bus.reti_req;
                        end
                    end
                end
                S_PUSH: begin
                    state       <= S_LOAD;
                    bus.pc_load <= 1'b1;
                end
                S_POP: begin
                    state <= S_WAIT;
                end
                // call_stack read data is valid here, one cycle after the pop strobe.
                S_WAIT: begin
                    state         <= S_LOAD;
                    bus.pc_load   <= 1'b1;
                    bus.pc_target <= bus.cs_data_out;
                    if (reti_q) begin
                        bus.in_isr <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!bus.stall) begin
                        state       <= S_IDLE;
                        bus.pc_load <= 1'b0;
                        bus.busy    <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    bus.pc_load <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_ctrl.sv
// Bench for call_ctrl: directed vectors, an emulated call_stack, and a
// transaction-level model compared against every output on every cycle.
module tb_call_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    call_ctrl_if bus ();

    call_ctrl #(.STACK_DEPTH(16), .IRQ_VECTOR(16'h0010)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Emulated call_stack: 16 entries, wraps silently, read data registered on pop.
    logic [15:0] stk_mem [16];
    logic [3:0]  stk_sp;
    always @(posedge clk) begin
        if (!rst) begin
            stk_sp          <= '0;
            bus.cs_data_out <= '0;
        end else if (bus.cs_push) begin
            stk_mem[stk_sp] <= bus.cs_data_in;
            stk_sp          <= stk_sp + 4'd1;
        end else if (bus.cs_pop) begin
            bus.cs_data_out <= stk_mem[stk_sp - 4'd1];
            stk_sp          <= stk_sp - 4'd1;
        end
    end

    // Model: each accepted request schedules the per-cycle output frames it implies.
    typedef struct packed {
        logic        push;
        logic        pop;
        logic        load;
        logic        busy;
        logic        taken;
        logic        ack;
        logic        set_tgt;
        logic        clr_isr;
        logic [15:0] tgt;
    } frame_t;

    localparam frame_t F_IDLE = '0;
    localparam int K_NONE = 0, K_IRQ = 1, K_RETI = 2, K_RET = 3, K_CALL = 4;

    frame_t      cur_f;
    frame_t      fq[$];
    logic [15:0] mstk[$];
    logic [15:0] e_din, e_tgt;
    logic        e_isr, e_ovf, e_unf;
    bit          model_ok = 0;

    function automatic frame_t mkf(input logic push, input logic pop, input logic load,
                                   input logic busy, input logic taken, input logic ack,
                                   input logic set_tgt, input logic clr_isr,
                                   input logic [15:0] tgt);
        frame_t f;
        f.push = push; f.pop = pop; f.load = load; f.busy = busy; f.taken = taken;
        f.ack = ack; f.set_tgt = set_tgt; f.clr_isr = clr_isr; f.tgt = tgt;
        return f;
    endfunction

    task automatic model_accept();
        int kind;
        logic [15:0] v;
        if (bus.irq_req && bus.irq_en && !e_isr) kind = K_IRQ;
        else if (bus.reti_req)                   kind = K_RETI;
        else if (bus.ret_req)                    kind = K_RET;
        else if (bus.call_req)                   kind = K_CALL;
        else                                     kind = K_NONE;
        if (kind == K_IRQ || kind == K_CALL) begin
            if (mstk.size() == 16) begin
                e_ovf = 1'b1;
                cur_f = mkf(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
            end else begin
                v = (kind == K_IRQ) ? bus.cur_pc : bus.ret_pc;
                mstk.push_back(v);
                e_din = v;
                e_tgt = (kind == K_IRQ) ? 16'h0010 : bus.call_addr;
                if (kind == K_IRQ) e_isr = 1'b1;
                cur_f = mkf(1, 0, 0, 1, 1, kind == K_IRQ, 0, 0, 16'h0);
                fq.push_back(mkf(0, 0, 1, 1, 0, 0, 0, 0, 16'h0));
            end
        end else if (kind == K_RET || kind == K_RETI) begin
            if (mstk.size() == 0) begin
                e_unf = 1'b1;
                cur_f = mkf(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
            end else begin
                v = mstk.pop_back();
                cur_f = mkf(0, 1, 0, 1, 1, 0, 0, 0, 16'h0);
                fq.push_back(mkf(0, 0, 0, 1, 0, 0, 0, 0, 16'h0));
                fq.push_back(mkf(0, 0, 1, 1, 0, 0, 1, kind == K_RETI, v));
            end
        end
    endtask

    initial begin
        cur_f = F_IDLE;
        forever begin
            @(posedge clk);
            if (!rst) begin
                cur_f = F_IDLE;
                fq.delete();
                mstk.delete();
                e_din = '0; e_tgt = '0; e_isr = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
                model_ok = 1;
            end else if (cur_f.busy) begin
                if (!(cur_f.load && bus.stall)) begin
                    if (fq.size() > 0) begin
                        cur_f = fq.pop_front();
                        if (cur_f.set_tgt) e_tgt = cur_f.tgt;
                        if (cur_f.clr_isr) e_isr = 1'b0;
                    end else begin
                        cur_f = F_IDLE;
                    end
                end
            end else begin
                cur_f = F_IDLE;
                if (!bus.stall) model_accept();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("m_cs_push",   16'(bus.cs_push),   16'(cur_f.push));
                chk("m_cs_pop",    16'(bus.cs_pop),    16'(cur_f.pop));
                chk("m_pc_load",   16'(bus.pc_load),   16'(cur_f.load));
                chk("m_busy",      16'(bus.busy),      16'(cur_f.busy));
                chk("m_req_taken", 16'(bus.req_taken), 16'(cur_f.taken));
                chk("m_irq_ack",   16'(bus.irq_ack),   16'(cur_f.ack));
                chk("m_in_isr",    16'(bus.in_isr),    16'(e_isr));
                chk("m_depth",     16'(bus.depth),     16'(mstk.size()));
                chk("m_fault_ovf", 16'(bus.fault_ovf), 16'(e_ovf));
                chk("m_fault_unf", 16'(bus.fault_unf), 16'(e_unf));
                chk("m_cs_data_in", bus.cs_data_in,    e_din);
                chk("m_pc_target",  bus.pc_target,     e_tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 30) begin
            tick();
            n++;
        end
        chk("idle_timeout", 16'(bus.busy), 16'h0);
    endtask

    task automatic do_call(input logic [15:0] addr, input logic [15:0] rp);
        bus.call_addr = addr;
        bus.ret_pc    = rp;
        bus.call_req  = 1'b1;
        tick();
        bus.call_req  = 1'b0;
    endtask

    task automatic do_ret(input logic reti, output logic [15:0] tgt);
        int n = 0;
        if (reti) bus.reti_req = 1'b1;
        else      bus.ret_req  = 1'b1;
        tick();
        bus.reti_req = 1'b0;
        bus.ret_req  = 1'b0;
        while (!bus.pc_load && n < 10) begin
            tick();
            n++;
        end
        chk("ret_load_seen", 16'(bus.pc_load), 16'h1);
        tgt = bus.pc_target;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] t;
        int n;
        bus.stall = 0; bus.call_req = 0; bus.ret_req = 0; bus.reti_req = 0;
        bus.irq_req = 0; bus.irq_en = 0; bus.call_addr = '0; bus.ret_pc = '0; bus.cur_pc = '0;

        rst = 1'b0;
        tick(); tick();
        chk("rst_depth",     16'(bus.depth),     16'h0);
        chk("rst_busy",      16'(bus.busy),      16'h0);
        chk("rst_pc_load",   16'(bus.pc_load),   16'h0);
        chk("rst_pc_target", bus.pc_target,      16'h0);
        chk("rst_data_in",   bus.cs_data_in,     16'h0);
        chk("rst_faults",    16'({bus.fault_ovf, bus.fault_unf, bus.in_isr}), 16'h0);
        rst = 1'b1;

        // Single CALL then RET
        do_call(16'h1234, 16'h0101);
        chk("call_push",    16'(bus.cs_push),   16'h1);
        chk("call_data_in", bus.cs_data_in,     16'h0101);
        chk("call_taken",   16'(bus.req_taken), 16'h1);
        tick();
        chk("call_load",    16'(bus.pc_load),   16'h1);
        chk("call_target",  bus.pc_target,      16'h1234);
        chk("call_depth",   16'(bus.depth),     16'h1);
        tick();
        chk("call_idle",    16'(bus.busy),      16'h0);
        bus.ret_req = 1'b1;
        tick();
        bus.ret_req = 1'b0;
        chk("ret_pop",      16'(bus.cs_pop),    16'h1);
        chk("ret_depth",    16'(bus.depth),     16'h0);
        tick();
        chk("ret_wait",     16'(bus.pc_load),   16'h0);
        tick();
        chk("ret_load",     16'(bus.pc_load),   16'h1);
        chk("ret_target",   bus.pc_target,      16'h0101);
        tick();

        // Fill to overflow, drain in LIFO order, then underflow
        for (int i = 0; i < 16; i++) begin
            do_call(16'h2000 + 16'(i), 16'h0A00 + 16'(i));
            wait_idle();
        end
        chk("full_depth", 16'(bus.depth), 16'd16);
        do_call(16'h2FFF, 16'h0BFF);
        chk("ovf_taken",  16'(bus.req_taken), 16'h1);
        chk("ovf_push",   16'(bus.cs_push),   16'h0);
        chk("ovf_flag",   16'(bus.fault_ovf), 16'h1);
        chk("ovf_busy",   16'(bus.busy),      16'h0);
        tick();
        chk("ovf_depth",  16'(bus.depth),     16'd16);
        for (int i = 0; i < 16; i++) begin
            do_ret(1'b0, t);
            chk("lifo_target", t, 16'h0A00 + 16'(15 - i));
        end
        chk("drain_depth", 16'(bus.depth), 16'h0);
        bus.ret_req = 1'b1;
        tick();
        bus.ret_req = 1'b0;
        chk("unf_taken", 16'(bus.req_taken), 16'h1);
        chk("unf_pop",   16'(bus.cs_pop),    16'h0);
        chk("unf_flag",  16'(bus.fault_unf), 16'h1);
        tick();

        // IRQ beats CALL; CALL follows; second irq blocked until RETI
        bus.irq_en = 1'b1; bus.cur_pc = 16'h0200;
        bus.call_addr = 16'h3000; bus.ret_pc = 16'h0300;
        bus.irq_req = 1'b1; bus.call_req = 1'b1;
        tick();
        chk("irq_ack",     16'(bus.irq_ack), 16'h1);
        chk("irq_push",    16'(bus.cs_push), 16'h1);
        chk("irq_data_in", bus.cs_data_in,   16'h0200);
        chk("irq_in_isr",  16'(bus.in_isr),  16'h1);
        bus.irq_req = 1'b0;
        tick();
        chk("irq_target",  bus.pc_target,    16'h0010);
        n = 0;
        while (!bus.req_taken && n < 10) begin
            tick();
            n++;
        end
        chk("call_after_irq", 16'(bus.req_taken), 16'h1);
        bus.call_req = 1'b0;
        chk("call_after_irq_data", bus.cs_data_in, 16'h0300);
        wait_idle();
        bus.irq_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("irq_blocked", 16'({bus.irq_ack, bus.busy}), 16'h0);
        end
        do_ret(1'b0, t);
        chk("ret_in_isr", t, 16'h0300);
        do_ret(1'b1, t);
        chk("reti_target", t, 16'h0200);
        chk("reti_clears", 16'(bus.in_isr), 16'h0);
        tick();
        chk("irq2_ack",    16'(bus.irq_ack), 16'h1);
        chk("irq2_in_isr", 16'(bus.in_isr),  16'h1);
        bus.irq_req = 1'b0;
        wait_idle();
        do_ret(1'b1, t);
        chk("reti2_target", t, 16'h0200);

        // Stall extends LOAD only
        do_call(16'h4000, 16'h0400);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_load",   16'(bus.pc_load), 16'h1);
            chk("stall_target", bus.pc_target,    16'h4000);
            tick();
        end
        bus.stall = 1'b0;
        chk("stall_load_last", 16'(bus.pc_load), 16'h1);
        tick();
        chk("stall_idle", 16'({bus.busy, bus.pc_load}), 16'h0);
        bus.ret_req = 1'b1;
        tick();
        bus.ret_req = 1'b0;
        bus.stall = 1'b1;
        chk("stall_pop", 16'(bus.cs_pop), 16'h1);
        tick();
        tick();
        chk("stall_ret_load",   16'(bus.pc_load), 16'h1);
        chk("stall_ret_target", bus.pc_target,    16'h0400);
        bus.stall = 1'b0;
        tick();

        // Reset during RET WAIT
        do_call(16'h5000, 16'h0500);
        wait_idle();
        bus.ret_req = 1'b1;
        tick();
        bus.ret_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_busy",   16'(bus.busy),    16'h0);
        chk("midrst_depth",  16'(bus.depth),   16'h0);
        chk("midrst_load",   16'(bus.pc_load), 16'h0);
        chk("midrst_target", bus.pc_target,    16'h0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_load", 16'(bus.pc_load), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
